// File: rtl/axi_slave_ram.sv
// axi_slave_ram: AXI4 slave responder backed by an on-chip dual-port RAM.
// Independent write (AW/W/B) and read (AR/R) engines, one outstanding burst per direction.
// Supports FIXED, INCR and WRAP bursts with byte strobes; errors answer with SLVERR.
//
// Ports:
//   aclk, areset                 clock, synchronous active-high reset (RAM contents kept)
//   aw*  (id/addr/len/size/burst, valid/ready)   write address channel
//   w*   (data/strb/last, valid/ready)           write data channel
//   b*   (id/resp, valid/ready)                  write response channel
//   ar*  (id/addr/len/size/burst, valid/ready)   read address channel
//   r*   (id/data/resp/last, valid/ready)        read data channel
//
// Optional build macro AXI_SLV_BACKPRESSURE_EN: a 16-bit LFSR injects pseudo-random
// wready stalls and extra read-fetch cycles. Undefined by default.
module axi_slave_ram #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned MEM_AW = 10
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LB     = $clog2(STRB_W);
    localparam int unsigned DEPTH  = 2 ** MEM_AW;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] BurstRsvd  = 2'b11;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_t;
    typedef enum logic [1:0] {RIdle, RFetch, RData} r_state_t;

    // Address of the following beat. Reserved burst type steps like INCR.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                     input logic [7:0]        len,
                                                     input logic [2:0]        size,
                                                     input logic [1:0]        burst);
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] mask;
        step = ADDR_W'(1) << size;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            BurstFixed: next_addr = addr;
            BurstWrap:  next_addr = (addr & ~mask) | ((addr + step) & mask);
            default:    next_addr = addr + step;
        endcase
    endfunction

    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        out_of_range = (addr >> (MEM_AW + LB)) != '0;
    endfunction

    // Burst-level errors detectable at the address handshake.
    function automatic logic cfg_error(input logic [7:0] len,
                                       input logic [2:0] size,
                                       input logic [1:0] burst);
        logic err;
        err = (burst == BurstRsvd) || (32'(size) > LB);
        if (burst == BurstWrap && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
            err = 1'b1;
        end
        return err;
    endfunction

    logic stall;

`ifdef AXI_SLV_BACKPRESSURE_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge aclk) begin
        if (areset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // ---------------------------------------------------------------- write engine
    w_state_t          w_state_q, w_state_d;
    logic [ID_W-1:0]   w_id_q, w_id_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [7:0]        w_len_q, w_len_d;
    logic [2:0]        w_size_q, w_size_d;
    logic [1:0]        w_burst_q, w_burst_d;
    logic [7:0]        w_cnt_q, w_cnt_d;
    logic              w_err_q, w_err_d;
    logic              mem_we;

    assign awready = !areset && (w_state_q == WIdle);
    assign wready  = !areset && (w_state_q == WData) && !stall;
    assign bvalid  = !areset && (w_state_q == WResp);
    assign bid     = bvalid ? w_id_q : '0;
    assign bresp   = (bvalid && w_err_q) ? RespSlverr : RespOkay;

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                if (awvalid && awready) begin
                    w_id_d    = awid;
                    w_addr_d  = awaddr;
                    w_len_d   = awlen;
                    w_size_d  = awsize;
                    w_burst_d = awburst;
                    w_cnt_d   = '0;
                    w_err_d   = cfg_error(awlen, awsize, awburst);
                    w_state_d = WData;
                end
            end
            WData: begin
                if (wvalid && wready) begin
                    // Out-of-range beats are swallowed but poison the response.
                    mem_we   = !out_of_range(w_addr_q);
                    w_err_d  = w_err_q || out_of_range(w_addr_q)
                               || (wlast != (w_cnt_q == w_len_q));
                    w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (w_cnt_q == w_len_q) begin
                        w_state_d = WResp;
                    end
                end
            end
            WResp: begin
                if (bvalid && bready) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q <= WIdle;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
        end
    end

    // ---------------------------------------------------------------- read engine
    r_state_t          r_state_q, r_state_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [7:0]        r_len_q, r_len_d;
    logic [2:0]        r_size_q, r_size_d;
    logic [1:0]        r_burst_q, r_burst_d;
    logic [7:0]        r_cnt_q, r_cnt_d;
    logic              r_err_q, r_err_d;
    logic              r_oob;
    logic [DATA_W-1:0] ram_rdata_q;

`ifdef AXI_SLV_BACKPRESSURE_EN
    logic r_hold_q, r_hold_d;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_hold_q <= 1'b0;
        end else begin
            r_hold_q <= r_hold_d;
        end
    end
`endif

    assign r_oob   = out_of_range(r_addr_q);
    assign arready = !areset && (r_state_q == RIdle);
    assign rvalid  = !areset && (r_state_q == RData);
    assign rid     = rvalid ? r_id_q : '0;
    assign rdata   = (rvalid && !r_oob) ? ram_rdata_q : '0;
    // Per-beat response: sticky burst error plus this beat's range check.
    assign rresp   = (rvalid && (r_err_q || r_oob)) ? RespSlverr : RespOkay;
    assign rlast   = rvalid && (r_cnt_q == r_len_q);

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_err_d   = r_err_q;
`ifdef AXI_SLV_BACKPRESSURE_EN
        r_hold_d  = 1'b0;
`endif
        unique case (r_state_q)
            RIdle: begin
                if (arvalid && arready) begin
                    r_id_d    = arid;
                    r_addr_d  = araddr;
                    r_len_d   = arlen;
                    r_size_d  = arsize;
                    r_burst_d = arburst;
                    r_cnt_d   = '0;
                    r_err_d   = cfg_error(arlen, arsize, arburst);
                    r_state_d = RFetch;
                end
            end
            RFetch: begin
`ifdef AXI_SLV_BACKPRESSURE_EN
                // One extra fetch cycle at most; the RAM simply re-reads the same word.
                if (stall && !r_hold_q) begin
                    r_hold_d = 1'b1;
                end else begin
                    r_state_d = RData;
                end
`else
                r_state_d = RData;
`endif
            end
            RData: begin
                if (rvalid && rready) begin
                    r_err_d = r_err_q || r_oob;
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = RIdle;
                    end else begin
                        r_addr_d  = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_state_d = RFetch;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q <= RIdle;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            r_err_q   <= r_err_d;
        end
    end

    // ---------------------------------------------------------------- RAM
    // No reset: contents survive areset. Read and write share an edge, so a
    // same-word collision returns the old data.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [MEM_AW-1:0] w_idx;
    logic [MEM_AW-1:0] r_idx;

    assign w_idx = w_addr_q[MEM_AW+LB-1:LB];
    assign r_idx = r_addr_q[MEM_AW+LB-1:LB];

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (r_state_q == RFetch) begin
            ram_rdata_q <= mem[r_idx];
        end
    end

endmodule
